instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
// Fetches 1- or 2-byte instructions from program memory. Presents opcode (IR), operand
// byte (OR2) and register select to the controller and RegisterArray stage.
// Sits directly upstream of the register array:
//   - or2_out drives OR2_in.
//   - rn_sel drives RN_Reg_Sel.
// Owns the program counter; accepts branch/jump reloads.
// PARAMETERS
// PC_W      8     program counter / program-memory address width
// RESET_PC  0     PC value loaded on reset
// PORTS
// clk          in   1     system clock, all state on rising edge
// rst          in   1     asynchronous, active-high reset
// halt         in   1     1 = do not start new fetches
// pc_load      in   1     1 = reload PC (branch/jump), flushes current fetch
// pc_load_val  in   PC_W  new PC value when pc_load=1
// pm_req       out  1     program-memory read request
// pm_addr      out  PC_W  program-memory read address (= pc while pm_req=1)
// pm_ack       in   1     memory returns pm_data this cycle (valid only while pm_req=1)
// pm_data      in   8     program-memory read data
// instr_valid  out  1     IR/OR2/rn_sel hold a complete instruction
// instr_ready  in   1     controller consumes instruction when instr_valid & instr_ready
// ir_out       out  8     opcode byte
// or2_out      out  8     operand byte (0x00 for 1-byte instructions)
// rn_sel       out  3     ir_out[2:0], register-array RN select
// pc_out       out  PC_W  current PC (address of next byte to fetch)
// BEHAVIOUR
// - Reset (async, rst=1):
//   - state=F_OP, pc=RESET_PC, ir_out=0x00, or2_out=0x00.
//   - instr_valid=0, pm_req=0.
// - Instruction length: opcode bit 7 = 1 -> 2-byte (operand follows); bit 7 = 0 -> 1-byte.
// - FSM states F_OP, F_OPND, HOLD:
//   - F_OP:
//     - pm_req = ~halt; pm_addr = pc.
//     - On pm_ack: ir_out <= pm_data; pc <= pc+1.
//       - pm_data[7]=1 -> F_OPND.
//       - pm_data[7]=0 -> or2_out <= 0x00; HOLD.
//   - F_OPND:
//     - pm_req = 1 (halt ignored; an instruction in progress is completed); pm_addr = pc.
//     - On pm_ack: or2_out <= pm_data; pc <= pc+1; -> HOLD.
//   - HOLD:
//     - instr_valid = 1; pm_req = 0.
//     - On instr_ready: -> F_OP.
//     - ir_out and or2_out stay stable until consumed.
// - Timing:
//   - pm_req is combinational from state/halt/pc_load.
//   - pm_req is held until pm_ack.
//   - A zero-wait memory (ack same cycle as req) gives:
//     - 1-byte instruction valid 1 cycle after its fetch starts.
//     - 2-byte instruction valid after 2 cycles.
//   - Back-to-back: the cycle after consume, F_OP issues the next request.
//     Maximum throughput is 1 instruction per 2 cycles (1-byte instructions).
// - pc_load has highest priority, in any state:
//   - pc <= pc_load_val; state <= F_OP; instr_valid = 0 next cycle.
//   - pm_req is forced 0 in the pc_load cycle.
//   - A pm_ack in that cycle is ignored (withdrawn request = cancelled by memory contract).
//   - ir_out/or2_out are not cleared; they are don't-care while instr_valid=0.
//   - pc_load while in HOLD with instr_ready=1: the pending instruction counts as consumed;
//     pc_load wins for PC.
// - PC arithmetic: modulo 2^PC_W; (2^PC_W - 1) + 1 wraps to 0, including mid-instruction.
// - halt:
//   - Only gates the start of a fetch in F_OP.
//   - Asserting halt while pm_req is pending in F_OP drops the request (cancelled).
//     The PC is unchanged.
// - rn_sel is always ir_out[2:0].
// - Reset mid-fetch: outputs return to reset values immediately; no pm_req while rst=1.
// TESTING
// 1. Reset, zero-wait memory: mem[0]=0x05 -> instr_valid in cycle 2;
//    ir=0x05, or2=0x00, rn_sel=5, pc=1.
// 2. Two-byte instruction: mem[1]=0x83, mem[2]=0x5A -> ir=0x83, or2=0x5A, rn_sel=3, pc=3.
//    pm_addr sequence 1,2.
// 3. Backpressure: hold instr_ready=0 for 5 cycles -> outputs stable, pm_req=0.
//    Ready=1 -> next fetch at the following cycle.
// 4. pc_load=1, pc_load_val=0x40 during F_OPND with a same-cycle pm_ack -> ack ignored;
//    next pm_addr=0x40.
// 5. Wrap: RESET_PC=0xFF, mem[0xFF]=0x81, mem[0x00]=0x22 -> or2=0x22, pc=0x01.
// 6. Wait-state memory (ack after 3 cycles) + halt asserted in F_OP -> req drops, PC held;
//    release -> fetch resumes at the same PC. Async rst mid-fetch -> pm_req=0 immediately.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches 1- or 2-byte instructions from program
// memory and holds opcode/operand/register-select for the controller and
// the register array until consumed. Owns the PC and accepts reloads.
module instr_fetch_unit #(
  parameter int unsigned    PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            halt,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_load_val,
  output logic            pm_req,
  output logic [PC_W-1:0] pm_addr,
  input  logic            pm_ack,
  input  logic [7:0]      pm_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [7:0]      ir_out,
  output logic [7:0]      or2_out,
  output logic [2:0]      rn_sel,
  output logic [PC_W-1:0] pc_out
);

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    F_OP   = 2'd0,
    F_OPND = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [BYTE_W-1:0] ir_q, ir_d;
  logic [BYTE_W-1:0] or2_q, or2_d;

  // State, PC and instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= F_OP;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      or2_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      or2_q   <= or2_d;
    end
  end

  // Next-state, fetch request and register updates; a PC reload overrides everything
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    or2_d       = or2_q;
    pm_req      = 1'b0;
    instr_valid = (state_q == HOLD);

    if (pc_load) begin
      pc_d    = pc_load_val;
      state_d = F_OP;
    end else begin
      case (state_q)
        F_OP: begin
          pm_req = ~halt;
          if (!halt && pm_ack) begin
            ir_d = pm_data;
            pc_d = pc_q + PC_W'(1);
            if (pm_data[7]) begin
              state_d = F_OPND;
            end else begin
              or2_d   = '0;
              state_d = HOLD;
            end
          end
        end
        F_OPND: begin
          // an instruction already started is completed regardless of halt
          pm_req = 1'b1;
          if (pm_ack) begin
            or2_d   = pm_data;
            pc_d    = pc_q + PC_W'(1);
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            state_d = F_OP;
          end
        end
        default: begin
          state_d = F_OP;
        end
      endcase
    end

    // no memory request may be seen while reset is held
    if (rst) begin
      pm_req = 1'b0;
    end
  end

  assign pm_addr = pc_q;
  assign pc_out  = pc_q;
  assign ir_out  = ir_q;
  assign or2_out = or2_q;
  assign rn_sel  = ir_q[2:0];

endmodule
